quadrature_emitter: RTL and testbench

Generates a two-phase quadrature (A/B Gray-code) output stream from step commands. It is the transmit-side counterpart of the board's rotary-encoder decoder. It drives test/emulation pins (or loops back internally) so the decoder, debouncers and LED mapping can be exercised without a physical dial. Commands arrive over a valid/ready handshake, each carrying a direction, a step count and a per-edge dwell time.

---
 rtl/quadrature_emitter.sv | 124 ++++++++++++
 tb/tb_quadrature_emitter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/quadrature_emitter.sv
// rtl/quadrature_emitter.sv - quadrature A/B Gray-code emitter driven by step commands
module quadrature_emitter #(
    parameter int COUNT_BITS = 8,
    parameter int DIV_BITS   = 16,
    parameter int POS_BITS   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_dir,
    input  logic [COUNT_BITS-1:0] cmd_steps,
    input  logic [DIV_BITS-1:0]   cmd_dwell,
    input  logic                  abort,
    output logic                  a,
    output logic                  b,
    output logic                  busy,
    output logic                  done,
    output logic [POS_BITS-1:0]   position
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [COUNT_BITS-1:0] C_ONE   = COUNT_BITS'(1);
    localparam logic [DIV_BITS-1:0]   D_ONE   = DIV_BITS'(1);
    localparam logic [POS_BITS-1:0]   P_ONE   = POS_BITS'(1);
    localparam logic [POS_BITS-1:0]   P_MINUS = '1;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_ready_en;
    logic                  r_dir;
    logic                  r_a;
    logic                  r_b;
    logic                  r_done;
    logic [COUNT_BITS-1:0] r_remaining;
    logic [DIV_BITS-1:0]   r_reload;
    logic [DIV_BITS-1:0]   r_timer;
    logic [POS_BITS-1:0]   r_position;
    logic                  w_accept;
    logic                  w_step;
    logic                  w_finish;
    logic [DIV_BITS-1:0]   w_dwell_m1;

    // A dwell of zero behaves like one, so the reload value saturates at zero.
    assign w_dwell_m1 = (cmd_dwell == '0) ? '0 : cmd_dwell - D_ONE;
    assign w_accept   = (r_state == S_IDLE) && r_ready_en && cmd_valid && !abort;

    always_comb begin
        w_next_state = r_state;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next_state = S_RUN;
            end
            S_RUN: begin
                if (abort) begin
                    w_next_state = S_IDLE;
                end else if (r_timer == '0) begin
                    if (r_remaining != '0) begin
                        w_step = 1'b1;
                    end else begin
                        w_finish     = 1'b1;
                        w_next_state = S_FIN;
                    end
                end
            end
            S_FIN:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready_en  <= 1'b0;
            r_dir       <= 1'b0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_done      <= 1'b0;
            r_remaining <= '0;
            r_reload    <= '0;
            r_timer     <= '0;
            r_position  <= '0;
        end else begin
            r_ready_en <= 1'b1;
            r_done     <= w_finish;
            if (w_accept) begin
                r_dir       <= cmd_dir;
                r_remaining <= cmd_steps;
                r_reload    <= w_dwell_m1;
                r_timer     <= w_dwell_m1;
            end else if (r_state == S_RUN && !abort) begin
                if (r_timer != '0) begin
                    r_timer <= r_timer - D_ONE;
                end else if (w_step) begin
                    // Up walks 00->10->11->01, down walks the reverse; one phase flips per step.
                    r_a         <= r_dir ? ~r_b : r_b;
                    r_b         <= r_dir ? r_a  : ~r_a;
                    r_position  <= r_position + (r_dir ? P_ONE : P_MINUS);
                    r_remaining <= r_remaining - C_ONE;
                    r_timer     <= r_reload;
                end
            end
        end
    end

    assign cmd_ready = (r_state == S_IDLE) && r_ready_en;
    assign busy      = (r_state != S_IDLE);
    assign a         = r_a;
    assign b         = r_b;
    assign done      = r_done;
    assign position  = r_position;

endmodule

// File: tb/tb_quadrature_emitter.sv
// tb/tb_quadrature_emitter.sv - self-checking bench for quadrature_emitter
module tb_quadrature_emitter;

    localparam int BIG = 1 << 30;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_dir = 1'b0;
    logic [7:0] cmd_steps = '0;
    logic [15:0] cmd_dwell = '0;
    logic       abort = 1'b0;
    logic       a, b, busy, done;
    logic [7:0] position;

    quadrature_emitter #(.COUNT_BITS(8), .DIV_BITS(16), .POS_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_dwell(cmd_dwell), .abort(abort),
        .a(a), .b(b), .busy(busy), .done(done), .position(position)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    // Command model: the current command is described by its schedule, and the
    // phase/position reached by earlier commands is folded into the base values.
    int m_have = 0, m_dir = 0, m_n = 0, m_d = 1;
    int m_c0 = BIG, m_ca = BIG, m_alive = BIG;
    int m_base_ph = 0, m_base_pos = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int imin(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

    function automatic int edges_at(input int c);
        if (!m_have || c < m_c0) return 0;
        if (c >= m_ca) return imin(m_n, (m_ca - m_c0 - 1) / m_d);
        return imin(m_n, (c - m_c0) / m_d);
    endfunction

    function automatic logic [1:0] ab_of(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic int wrap(input int x, input int m);
        return ((x % m) + m) % m;
    endfunction

    int          x_ed, x_sg, x_e;
    logic [1:0]  x_ab;
    logic [7:0]  x_pos;
    logic        x_busy, x_done, x_ready;

    always @(negedge clk) begin
        x_ed    = edges_at(cyc);
        x_sg    = m_dir ? 1 : -1;
        x_e     = cyc - m_c0;
        x_ab    = ab_of(wrap(m_base_ph + x_sg * x_ed, 4));
        x_pos   = 8'(wrap(m_base_pos + x_sg * x_ed, 256));
        x_busy  = m_have && x_e >= 0 && cyc < m_ca && x_e <= (m_n + 1) * m_d;
        x_done  = m_have && x_e >= 0 && cyc < m_ca && x_e == (m_n + 1) * m_d;
        x_ready = !x_busy && cyc >= m_alive;
        chk("cmp_ab", {30'd0, a, b}, {30'd0, x_ab});
        chk("cmp_position", {24'd0, position}, {24'd0, x_pos});
        chk("cmp_busy", {31'd0, busy}, {31'd0, x_busy});
        chk("cmp_done", {31'd0, done}, {31'd0, x_done});
        chk("cmp_ready", {31'd0, cmd_ready}, {31'd0, x_ready});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic model_commit();
        int ed;
        if (m_have) begin
            ed = (m_ca != BIG) ? imin(m_n, (m_ca - m_c0 - 1) / m_d) : m_n;
            m_base_ph  = wrap(m_base_ph + (m_dir ? ed : -ed), 4);
            m_base_pos = wrap(m_base_pos + (m_dir ? ed : -ed), 256);
        end
    endtask

    task automatic issue(input int dir, input int n, input int d, output int c0);
        model_commit();
        m_dir = dir; m_n = n; m_d = (d == 0) ? 1 : d;
        m_c0 = cyc + 1; m_ca = BIG; m_have = 1;
        c0 = m_c0;
        cmd_dir   = dir[0];
        cmd_steps = n[7:0];
        cmd_dwell = d[15:0];
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd_dir   = 1'($urandom);
        cmd_steps = 8'($urandom);
        cmd_dwell = 16'($urandom);
    endtask

    task automatic do_abort();
        abort = 1'b1;
        m_ca  = cyc + 1;
        tick();
        abort = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        m_have = 0; m_c0 = BIG; m_ca = BIG; m_alive = BIG;
        m_base_ph = 0; m_base_pos = 0;
        #1;
        chk("rst_ab", {30'd0, a, b}, 32'd0);
        chk("rst_position", {24'd0, position}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        #1;
        rst_n   = 1'b1;
        m_alive = cyc + 1;
        #1;
        chk("rst_ready_low", {31'd0, cmd_ready}, 32'd0);
        tick();
        chk("rst_ready_high", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        do_reset();

        // Down 5 steps at dwell 1 from the reset phase.
        issue(0, 5, 1, c0);
        wait_to(c0 + 1);
        chk("t3_ab1", {30'd0, a, b}, 32'd1);
        chk("t3_pos1", {24'd0, position}, 32'd255);
        wait_to(c0 + 3);
        chk("t3_ab3", {30'd0, a, b}, 32'd2);
        wait_to(c0 + 5);
        chk("t3_ab5", {30'd0, a, b}, 32'd1);
        chk("t3_pos5", {24'd0, position}, 32'd251);
        wait_to(c0 + 8);

        do_reset();
        // Up 4 steps at dwell 3; cmd_valid is waved while busy and must be ignored.
        issue(1, 4, 3, c0);
        cmd_valid = 1'b1;
        wait_to(c0 + 3);
        chk("t2_ab3", {30'd0, a, b}, 32'd2);
        chk("t2_pos3", {24'd0, position}, 32'd1);
        wait_to(c0 + 6);
        chk("t2_ab6", {30'd0, a, b}, 32'd3);
        wait_to(c0 + 9);
        chk("t2_ab9", {30'd0, a, b}, 32'd1);
        wait_to(c0 + 10);
        cmd_valid = 1'b0;
        wait_to(c0 + 12);
        chk("t2_ab12", {30'd0, a, b}, 32'd0);
        chk("t2_pos12", {24'd0, position}, 32'd4);
        wait_to(c0 + 14);
        chk("t2_done14", {31'd0, done}, 32'd0);
        wait_to(c0 + 15);
        chk("t2_done15", {31'd0, done}, 32'd1);
        wait_to(c0 + 16);
        chk("t2_ready16", {31'd0, cmd_ready}, 32'd1);

        // Zero steps with zero dwell, then zero dwell with two steps.
        issue(1, 0, 0, c0);
        wait_to(c0 + 1);
        chk("t4_done1", {31'd0, done}, 32'd1);
        wait_to(c0 + 2);
        issue(1, 2, 0, c0);
        wait_to(c0 + 1);
        chk("t4_ab1", {30'd0, a, b}, 32'd2);
        wait_to(c0 + 2);
        chk("t4_ab2", {30'd0, a, b}, 32'd3);
        chk("t4_pos2", {24'd0, position}, 32'd6);
        wait_to(c0 + 5);

        do_reset();
        // Abort during the third dwell interval.
        issue(1, 10, 4, c0);
        wait_to(c0 + 9);
        do_abort();
        chk("t5_busy10", {31'd0, busy}, 32'd0);
        chk("t5_ab10", {30'd0, a, b}, 32'd3);
        chk("t5_pos10", {24'd0, position}, 32'd2);
        wait_to(c0 + 14);
        chk("t5_ab14", {30'd0, a, b}, 32'd3);
        issue(1, 1, 1, c0);
        wait_to(c0 + 1);
        chk("t5_next_ab", {30'd0, a, b}, 32'd1);
        chk("t5_next_pos", {24'd0, position}, 32'd3);
        wait_to(c0 + 3);

        // abort in IDLE is ignored, and blocks a simultaneous accept.
        cmd_valid = 1'b1;
        abort     = 1'b1;
        tick();
        cmd_valid = 1'b0;
        abort     = 1'b0;
        chk("idle_abort_busy", {31'd0, busy}, 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        chk("idle_abort_ready", {31'd0, cmd_ready}, 32'd1);

        // Asynchronous reset in the middle of a command.
        issue(1, 10, 2, c0);
        wait_to(c0 + 5);
        do_reset();
        issue(0, 2, 1, c0);
        wait_to(c0 + 1);
        chk("t6_ab1", {30'd0, a, b}, 32'd1);
        chk("t6_pos1", {24'd0, position}, 32'd255);
        wait_to(c0 + 2);
        chk("t6_ab2", {30'd0, a, b}, 32'd3);
        wait_to(c0 + 3);
        chk("t6_done3", {31'd0, done}, 32'd1);
        wait_to(c0 + 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
